// File: rtl/bomb_pkg.sv
// Shared types and command codes for the bomb game controller and its
// countdown command bus.
package bomb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_SETTLE,
    ST_RUNNING,
    ST_STOP,
    ST_DEFUSED,
    ST_EXPLODED
  } game_state_t;

  localparam logic [7:0] CMD_TOGGLE = 8'h10;
  localparam logic [7:0] CMD_NONE   = 8'h00;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bomb_game_ctrl_if.sv
// Controller <-> countdown link: start time, run/stop command bus, seconds
// tick, and the three BCD digits fed back from the countdown.
interface bomb_game_ctrl_if;
  import bomb_pkg::*;

  logic [11:0] init_time;
  logic [7:0]  switch_op;
  logic        sec_timer;
  bcd_digit_t  value_three;
  bcd_digit_t  value_two;
  bcd_digit_t  value_one;

  modport master (
    output init_time, switch_op, sec_timer,
    input  value_three, value_two, value_one
  );

  modport slave (
    input  init_time, switch_op, sec_timer,
    output value_three, value_two, value_one
  );

endinterface

// File: rtl/tick_divider.sv
// Seconds-tick generator: period TICK_DIV >> shift, held at zero while clr
// is high so the first tick after release lands a full period later.
module tick_divider #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic [1:0] shift,
  output logic       tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [31:0]   period;
  logic [CW-1:0] last;
  logic [CW-1:0] cnt_q, cnt_d;

  assign period = 32'(TICK_DIV) >> shift;
  assign last   = CW'(period - 32'd1);
  assign tick   = !clr && (cnt_q == last);

  always_comb begin
    cnt_d = (clr || tick) ? '0 : cnt_q + CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bomb_game_ctrl.sv
// Round sequencer: arms and stops the countdown, paces its seconds tick by
// strike count, and resolves each round to DEFUSED or EXPLODED.
module bomb_game_ctrl
  import bomb_pkg::*;
#(
  parameter int          TICK_DIV    = 50_000_000,
  parameter int          MAX_STRIKES = 3,
  parameter logic [11:0] INIT_TIME   = 12'h300
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic             disarm_ok,
  input  logic             strike,
  output logic [1:0]       strikes,
  output logic             running,
  output logic             defused,
  output logic             exploded,
  bomb_game_ctrl_if.master cd
);

  localparam logic [1:0] MAX_S = 2'(MAX_STRIKES);

  game_state_t state_q, state_d;
  game_state_t target_q, target_d;
  logic [1:0]  strikes_q, strikes_d;
  logic        div_clr;
  logic        tick;
  logic        time_zero;

  assign time_zero = ({cd.value_three, cd.value_two, cd.value_one} == 12'h000);

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (div_clr),
    .shift (strikes_q),
    .tick  (tick)
  );

  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    strikes_d = strikes_q;
    div_clr   = 1'b1;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_ARM;
      ST_ARM:    state_d = ST_SETTLE;
      ST_SETTLE: state_d = ST_RUNNING;
      ST_RUNNING: begin
        // A strike restarts the period so the new, shorter rate starts cleanly.
        div_clr = strike;
        if (strike && strikes_q != MAX_S) strikes_d = strikes_q + 2'd1;
        if (strike && strikes_d == MAX_S) begin
          state_d  = ST_STOP;
          target_d = ST_EXPLODED;
        end else if (time_zero) begin
          state_d  = ST_STOP;
          target_d = ST_EXPLODED;
        end else if (disarm_ok) begin
          state_d  = ST_STOP;
          target_d = ST_DEFUSED;
        end
      end
      ST_STOP:   state_d = target_q;
      ST_DEFUSED, ST_EXPLODED: begin
        if (clear) begin
          state_d   = ST_IDLE;
          strikes_d = 2'd0;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      target_q  <= ST_EXPLODED;
      strikes_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      strikes_q <= strikes_d;
    end
  end

  assign cd.init_time = INIT_TIME;
  assign cd.switch_op = (state_q == ST_ARM || state_q == ST_STOP) ? CMD_TOGGLE : CMD_NONE;
  assign cd.sec_timer = tick;
  assign strikes      = strikes_q;
  assign running      = (state_q == ST_RUNNING);
  assign defused      = (state_q == ST_DEFUSED);
  assign exploded     = (state_q == ST_EXPLODED);

endmodule

// File: tb/tb_bomb_game_ctrl.sv
// Directed bench for bomb_game_ctrl with a behavioural BCD countdown and a
// scoreboard of expected digit values consumed on every seconds tick.
module tb_bomb_game_ctrl;
  import bomb_pkg::*;

  localparam int          TICK_DIV  = 16;
  localparam logic [11:0] INIT_TIME = 12'h012;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, clear = 1'b0, disarm_ok = 1'b0, strike = 1'b0;
  logic [1:0] strikes;
  logic       running, defused, exploded;

  bomb_game_ctrl_if cd();

  bomb_game_ctrl #(
    .TICK_DIV    (TICK_DIV),
    .MAX_STRIKES (3),
    .INIT_TIME   (INIT_TIME)
  ) dut (
    .clk       (clk),
    .reset     (rst_n),
    .start     (start),
    .clear     (clear),
    .disarm_ok (disarm_ok),
    .strike    (strike),
    .strikes   (strikes),
    .running   (running),
    .defused   (defused),
    .exploded  (exploded),
    .cd        (cd)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (r[3:0] != 4'd0) r[3:0] = r[3:0] - 4'd1;
    else begin
      r[3:0] = 4'd9;
      if (r[7:4] != 4'd0) r[7:4] = r[7:4] - 4'd1;
      else begin
        r[7:4]  = 4'd9;
        r[11:8] = r[11:8] - 4'd1;
      end
    end
    return r;
  endfunction

  // Countdown: registers the command, toggles run (loading on start,
  // freezing on stop), decrements one second per tick, saturates at 000.
  logic [11:0] dig;
  logic        cd_run, cd_cmd_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig      <= 12'h000;
      cd_run   <= 1'b0;
      cd_cmd_q <= 1'b0;
    end else begin
      cd_cmd_q <= (cd.switch_op == CMD_TOGGLE);
      if (cd_cmd_q) begin
        if (!cd_run) begin
          dig    <= cd.init_time;
          cd_run <= 1'b1;
        end else cd_run <= 1'b0;
      end else if (cd_run && cd.sec_timer && dig != 12'h000) begin
        dig <= bcd_dec(dig);
      end
    end
  end
  assign cd.value_three = dig[11:8];
  assign cd.value_two   = dig[7:4];
  assign cd.value_one   = dig[3:0];

  int          n_cmp = 0, n_err = 0;
  int          cyc = 0, tick_cnt = 0, last_tick_cyc = 0, last_gap = 0, op_cnt = 0;
  logic        prev_tick = 1'b0;
  logic [11:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    cyc++;
    if (prev_tick) begin
      check("sb_avail", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("digits", 32'(dig), 32'(exp_q.pop_front()));
    end
    if (cd.sec_timer) begin
      check("tick_no_op", 32'(cd.switch_op), 0);
      check("tick_in_run", 32'(running), 1);
      last_gap      = cyc - last_tick_cyc;
      last_tick_cyc = cyc;
      tick_cnt++;
    end
    if (cd.switch_op == CMD_TOGGLE) op_cnt++;
    prev_tick = cd.sec_timer;
  endtask

  // Inputs are applied at posedge+1, sampled at the negedge, consumed at the
  // next posedge, then the pulses are dropped.
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    start = 1'b0; clear = 1'b0; disarm_ok = 1'b0; strike = 1'b0;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_dig(input logic [11:0] target, input int bound);
    int k = 0;
    while (dig !== target && k < bound) begin step(); k++; end
    check("reach_digits", 32'(dig), 32'(target));
  endtask

  task automatic wait_ticks(input int n, input int bound);
    int goal = tick_cnt + n;
    int k = 0;
    while (tick_cnt < goal && k < bound) begin step(); k++; end
    check("ticks_seen", tick_cnt, goal);
  endtask

  task automatic wait_end(input int bound);
    int k = 0;
    while (!(exploded || defused) && k < bound) begin step(); k++; end
    check("round_ended", 32'(exploded || defused), 1);
  endtask

  task automatic start_round();
    logic [11:0] v;
    exp_q.delete();
    v = INIT_TIME;
    while (v != 12'h000) begin
      v = bcd_dec(v);
      exp_q.push_back(v);
    end
    op_cnt   = 0;
    tick_cnt = 0;
    start = 1'b1;
    step();
    check("arm_op", 32'(cd.switch_op), 32'(CMD_TOGGLE));
    step();
    check("settle_no_op", 32'(cd.switch_op), 0);
    step();
    check("load_dig", 32'(dig), 32'(INIT_TIME));
    check("running", 32'(running), 1);
  endtask

  initial begin
    int n;
    int t0;

    #12;
    check("rst_running", 32'(running), 0);
    check("rst_strikes", 32'(strikes), 0);
    check("rst_op", 32'(cd.switch_op), 0);
    check("rst_tick", 32'(cd.sec_timer), 0);
    check("rst_flags", 32'({defused, exploded}), 0);
    check("init_time", 32'(cd.init_time), 32'(INIT_TIME));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step_n(2);

    // Start, load latency, first tick on the 16th RUNNING cycle.
    start_round();
    n = 0;
    while (!cd.sec_timer && n < 64) begin step(); n++; end
    check("first_tick_cyc", n, 15);

    // Untouched round runs down to 000 and explodes.
    wait_end(400);
    check("timeout_exploded", 32'(exploded), 1);
    check("timeout_not_defused", 32'(defused), 0);
    check("timeout_strikes", 32'(strikes), 0);
    check("timeout_ticks", tick_cnt, 12);
    check("timeout_op_pulses", op_cnt, 2);
    check("timeout_digits", 32'(dig), 0);
    check("sb_drained", exp_q.size(), 0);

    start = 1'b1;
    step();
    check("start_ignored", 32'(exploded), 1);
    check("start_ignored_op", 32'(cd.switch_op), 0);
    clear = 1'b1;
    step();
    check("clear_idle", 32'({running, defused, exploded}), 0);

    // Strikes shorten the period, the third explodes.
    start_round();
    wait_dig(12'h008, 200);
    strike = 1'b1;
    step();
    check("strike1", 32'(strikes), 1);
    wait_ticks(2, 64);
    check("period_s1", last_gap, 8);
    strike = 1'b1;
    step();
    check("strike2", 32'(strikes), 2);
    wait_ticks(2, 64);
    check("period_s2", last_gap, 4);
    strike = 1'b1;
    step();
    check("stop_op", 32'(cd.switch_op), 32'(CMD_TOGGLE));
    check("stop_no_tick", 32'(cd.sec_timer), 0);
    step();
    check("exploded_s3", 32'(exploded), 1);
    check("strikes_sat", 32'(strikes), 3);
    exp_q.delete();
    clear = 1'b1;
    step();
    check("strikes_clr", 32'(strikes), 0);

    // Disarm at 005: stop, freeze, no further ticks.
    start_round();
    wait_dig(12'h005, 200);
    disarm_ok = 1'b1;
    step();
    check("disarm_stop_op", 32'(cd.switch_op), 32'(CMD_TOGGLE));
    step();
    check("defused", 32'(defused), 1);
    check("defused_not_expl", 32'(exploded), 0);
    t0 = tick_cnt;
    step_n(40);
    check("no_tick_after", tick_cnt, t0);
    check("frozen", 32'(dig), 32'h005);
    check("sb_left", exp_q.size(), 5);
    exp_q.delete();
    clear = 1'b1;
    step();
    check("clear_flags", 32'({running, defused, exploded}), 0);

    // Same-cycle strike reaching max beats disarm.
    start_round();
    strike = 1'b1;
    step();
    strike = 1'b1;
    step();
    check("race_pre", 32'(strikes), 2);
    strike = 1'b1; disarm_ok = 1'b1;
    step();
    step();
    check("race_max_explodes", 32'(exploded), 1);
    check("race_max_not_def", 32'(defused), 0);
    check("race_max_strikes", 32'(strikes), 3);
    exp_q.delete();
    clear = 1'b1;
    step();

    // Same-cycle low strike still counts, disarm wins.
    start_round();
    strike = 1'b1; disarm_ok = 1'b1;
    step();
    step();
    check("race_low_defused", 32'(defused), 1);
    check("race_low_strikes", 32'(strikes), 1);
    exp_q.delete();
    clear = 1'b1;
    step();

    // Asynchronous reset in the middle of a round.
    start_round();
    step_n(20);
    strike = 1'b1;
    step();
    check("pre_rst_strikes", 32'(strikes), 1);
    step_n(3);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_running", 32'(running), 0);
    check("mid_rst_strikes", 32'(strikes), 0);
    check("mid_rst_op_tick", 32'({cd.switch_op, cd.sec_timer}), 0);
    check("mid_rst_flags", 32'({defused, exploded}), 0);
    check("mid_rst_digits", 32'(dig), 0);
    #2 rst_n = 1'b1;
    prev_tick = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    step_n(3);
    check("post_rst_idle", 32'({running, defused, exploded, cd.switch_op}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
